// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for the digit-serial BCD adder.
// BCD_SERIAL_SUB_EN adds the sub request bit.
interface bcd_serial_adder_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  cin;
`ifdef BCD_SERIAL_SUB_EN
   logic                  sub;
`endif
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
   logic                  busy;
   logic                  done;
   logic                  invalid;

`ifdef BCD_SERIAL_SUB_EN
   modport master (
      output start, a, b, cin, sub,
      input  sum, cout, busy, done, invalid
   );
   modport slave (
      input  start, a, b, cin, sub,
      output sum, cout, busy, done, invalid
   );
`else
   modport master (
      output start, a, b, cin,
      input  sum, cout, busy, done, invalid
   );
   modport slave (
      input  start, a, b, cin,
      output sum, cout, busy, done, invalid
   );
`endif
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one decimal digit per clock, LSB first.
// Define BCD_SERIAL_SUB_EN for tens-complement subtraction (sub bit).
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input logic              clk,
   input logic              rst,
   bcd_serial_adder_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t state;
   state_t nstate;

   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic [IW-1:0] idx_q;
   logic          carry_q;
   logic          cout_q;
   logic          inv_q;
   logic          sub_q;

   logic [3:0] ad;
   logic [3:0] bd;
   logic [3:0] bx;
   logic [4:0] t;
   logic [3:0] dig;
   logic       dc;
   logic       dinv;
   logic       last;
   logic       cin0;
   logic       sub_in;

`ifdef BCD_SERIAL_SUB_EN
   assign sub_in = bus.sub;
`else
   assign sub_in = 1'b0;
`endif

   // Subtraction starts with the +1 of the tens complement.
   assign cin0 = sub_in ? 1'b1 : bus.cin;

   // Select the current digit of each latched operand.
   always_comb begin
      ad = '0;
      bd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            ad = a_q[4*i +: 4];
            bd = b_q[4*i +: 4];
         end
      end
   end

   // Shared 4-bit slice with decimal correction.
   always_comb begin
      bx   = sub_q ? (4'd9 - bd) : bd;
      t    = {1'b0, ad} + {1'b0, bx} + {4'd0, carry_q};
      dig  = t[3:0];
      dc   = 1'b0;
      if (t > 5'd9) begin
         dig = t[3:0] + 4'd6;
         dc  = 1'b1;
      end
      dinv = (ad > 4'd9) || (bd > 4'd9);
      last = (idx_q == LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: if (bus.start) nstate = ADD;
         ADD:  if (last) nstate = DONE;
         DONE: nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         inv_q   <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  sub_q   <= sub_in;
                  carry_q <= cin0;
                  idx_q   <= '0;
                  inv_q   <= 1'b0;
                  sum_q   <= '0;
               end
            end
            ADD: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (idx_q == IW'(i)) sum_q[4*i +: 4] <= dig;
               end
               carry_q <= dc;
               inv_q   <= inv_q | dinv;
               idx_q   <= idx_q + IW'(1);
               if (last) cout_q <= dc;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.sum     = sum_q;
   assign bus.cout    = cout_q;
   assign bus.invalid = inv_q;
   assign bus.busy    = (state == ADD);
   assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomised and directed bench for bcd_serial_adder.
// Reference model works on whole decimal integers.
module tb_bcd_serial_adder;
   localparam int D = 4;
   localparam int W = 4 * D;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcd_serial_adder_if #(.DIGITS(D)) bus ();
   bcd_serial_adder #(.DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         inv;
      bit           def;
   } exp_t;

   exp_t q[$];
   exp_t last;
   exp_t cur;
   bit   have_last = 0;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic s);
      exp_t   e;
      longint av = 0;
      longint bv = 0;
      longint m  = 1;
      longint r;
      int     dg;
      e.inv = 1'b0;
      for (int i = D - 1; i >= 0; i--) begin
         dg = int'(a[4*i +: 4]);
         if (dg > 9) e.inv = 1'b1;
         av = av * 10 + dg;
         dg = int'(b[4*i +: 4]);
         if (dg > 9) e.inv = 1'b1;
         bv = bv * 10 + dg;
         m  = m * 10;
      end
      if (s) begin
         r = av - bv;
         e.cout = (r >= 0);
         if (r < 0) r = r + m;
      end else begin
         r = av + bv + (c ? 1 : 0);
         e.cout = (r >= m);
         if (r >= m) r = r - m;
      end
      e.sum = '0;
      for (int i = 0; i < D; i++) begin
         e.sum[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      e.def = !e.inv;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         last.sum  = '0;
         last.cout = 1'b0;
         last.inv  = 1'b0;
         last.def  = 1'b1;
         have_last = 1;
      end else if (bus.done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done actual=1 required=0");
         end else begin
            cur = q.pop_front();
            chk("done_invalid", W'(bus.invalid), W'(cur.inv));
            chk("done_busy", W'(bus.busy), W'(0));
            if (cur.def) begin
               chk("done_sum", bus.sum, cur.sum);
               chk("done_cout", W'(bus.cout), W'(cur.cout));
            end
            last = cur;
         end
      end else if (!bus.busy && have_last) begin
         chk("idle_invalid", W'(bus.invalid), W'(last.inv));
         if (last.def) begin
            chk("idle_sum", bus.sum, last.sum);
            chk("idle_cout", W'(bus.cout), W'(last.cout));
         end
      end
   end

   task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s, input bit lit,
                      input logic [W-1:0] ls, input logic lc,
                      input logic li, input bit inject);
      int n    = 0;
      int nb   = 0;
      bit seen = 0;
      @(negedge clk);
      while ((bus.busy || bus.done) && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.a   = a;
      bus.b   = b;
      bus.cin = c;
`ifdef BCD_SERIAL_SUB_EN
      bus.sub = s;
`endif
      bus.start = 1'b1;
      q.push_back(model(a, b, c, s));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.cin   = 1'($urandom);
      for (int k = 1; k <= D + 4; k++) begin
         @(negedge clk);
         if (bus.busy) nb++;
         if (inject && k == 2) begin
            bus.start = 1'b1;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
         end
         if (bus.done) begin
            seen = 1;
            chk("latency", W'(k), W'(D + 1));
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=0 required=1");
         q.delete();
      end
      chk("busy_cycles", W'(nb), W'(D));
      if (seen && lit) begin
         chk("lit_invalid", W'(bus.invalid), W'(li));
         if (!li) begin
            chk("lit_sum", bus.sum, ls);
            chk("lit_cout", W'(bus.cout), W'(lc));
         end
      end
      if (inject) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         @(negedge clk);
         chk("ignored_start_busy", W'(bus.busy), W'(0));
      end
   endtask

   task automatic reset_mid();
      @(negedge clk);
      bus.a     = 16'h4321;
      bus.b     = 16'h1111;
      bus.cin   = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_sum", bus.sum, W'(0));
      chk("rst_cout", W'(bus.cout), W'(0));
      chk("rst_busy", W'(bus.busy), W'(0));
      chk("rst_done", W'(bus.done), W'(0));
      chk("rst_invalid", W'(bus.invalid), W'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t pin;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
`ifdef BCD_SERIAL_SUB_EN
      bus.sub = 1'b0;
`endif
      @(negedge clk);
      chk("reset_sum", bus.sum, W'(0));
      chk("reset_busy", W'(bus.busy), W'(0));
      chk("reset_done", W'(bus.done), W'(0));
      chk("reset_cout", W'(bus.cout), W'(0));
      chk("reset_invalid", W'(bus.invalid), W'(0));

      pin = model(16'h1234, 16'h5678, 1'b0, 1'b0);
      chk("model_pin_sum", pin.sum, 16'h6912);
      pin = model(16'h0999, 16'h0001, 1'b1, 1'b0);
      chk("model_pin_carry", pin.sum, 16'h1001);
      @(negedge clk);
      rst = 1'b0;

      run(16'h1234, 16'h5678, 1'b0, 1'b0, 1, 16'h6912, 1'b0, 1'b0, 0);
      run(16'h9999, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 0);
      run(16'h0999, 16'h0001, 1'b1, 1'b0, 1, 16'h1001, 1'b0, 1'b0, 0);
      run(16'h00A0, 16'h0000, 1'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b1, 0);
      run(16'h0001, 16'h0001, 1'b0, 1'b0, 1, 16'h0002, 1'b0, 1'b0, 0);
      run(16'h1111, 16'h2222, 1'b0, 1'b0, 1, 16'h3333, 1'b0, 1'b0, 1);
      run(16'h9999, 16'h9999, 1'b1, 1'b0, 1, 16'h9999, 1'b1, 1'b0, 0);
      reset_mid();
      run(16'h0005, 16'h0005, 1'b0, 1'b0, 1, 16'h0010, 1'b0, 1'b0, 0);
`ifdef BCD_SERIAL_SUB_EN
      run(16'h0500, 16'h0123, 1'b0, 1'b1, 1, 16'h0377, 1'b1, 1'b0, 0);
      run(16'h0123, 16'h0500, 1'b1, 1'b1, 1, 16'h9623, 1'b0, 1'b0, 0);
`endif

      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < D; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(0, 9));
            rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 99) < 12) begin
            ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         end
         if ($urandom_range(0, 99) < 8) begin
            rb[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         end
`ifdef BCD_SERIAL_SUB_EN
         run(ra, rb, 1'($urandom), 1'($urandom), 0, '0, 1'b0, 1'b0,
             ($urandom_range(0, 9) == 0));
`else
         run(ra, rb, 1'($urandom), 1'b0, 0, '0, 1'b0, 1'b0,
             ($urandom_range(0, 9) == 0));
`endif
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
